// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state type and vote helper
package uart_pkg;

  localparam int DATA_BITS         = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - 2-flop line synchronizer, reset to idle-high
// UART_RX_MAJORITY_EN adds a 3-sample majority vote behind the synchronizer.
module uart_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);
  import uart_pkg::*;

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two older samples plus the current one; a lone spike never wins the vote.
  logic [1:0] r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_sync};
    end
  end

  assign o_sync = maj3(r_sync, r_hist[0], r_hist[1]);
`else
  assign o_sync = r_sync;
`endif

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid and framing-error pulses
// Optional input majority filter: UART_RX_MAJORITY_EN (inside uart_sync).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_rx_state_t       r_state,   w_state_nx;
  logic [CNT_W-1:0]     r_clk_cnt, w_clk_cnt_nx;
  logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_nx;
  logic [DATA_BITS-1:0] r_shift,   w_shift_nx;
  logic [DATA_BITS-1:0] r_data,    w_data_nx;
  logic                 r_valid,   w_valid_nx;
  logic                 r_err,     w_err_nx;

  uart_sync u_sync (
    .i_clk   (r_clk),
    .i_rst_n (r_rst),
    .i_async (rx_in),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_clk_cnt <= w_clk_cnt_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_shift   <= w_shift_nx;
      r_data    <= w_data_nx;
      r_valid   <= w_valid_nx;
      r_err     <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_clk_cnt_nx = r_clk_cnt;
    w_bit_idx_nx = r_bit_idx;
    w_shift_nx   = r_shift;
    w_data_nx    = r_data;
    w_valid_nx   = 1'b0;
    w_err_nx     = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nx   = START;
          w_clk_cnt_nx = '0;
        end
      end

      // Re-check the line at mid start bit so short low pulses are ignored.
      START: begin
        if (r_clk_cnt == HALF_M1) begin
          w_clk_cnt_nx = '0;
          if (!w_rx_s) begin
            w_state_nx   = DATA;
            w_bit_idx_nx = '0;
          end else begin
            w_state_nx = IDLE;
          end
        end else begin
          w_clk_cnt_nx = r_clk_cnt + 1'b1;
        end
      end

      DATA: begin
        if (r_clk_cnt == FULL_M1) begin
          w_clk_cnt_nx          = '0;
          w_shift_nx[r_bit_idx] = w_rx_s;
          if (r_bit_idx == LAST_IDX) begin
            w_state_nx = STOP;
          end else begin
            w_bit_idx_nx = r_bit_idx + 1'b1;
          end
        end else begin
          w_clk_cnt_nx = r_clk_cnt + 1'b1;
        end
      end

      STOP: begin
        if (r_clk_cnt == FULL_M1) begin
          w_clk_cnt_nx = '0;
          if (w_rx_s) begin
            w_data_nx  = r_shift;
            w_valid_nx = 1'b1;
            w_state_nx = IDLE;
          end else begin
            w_err_nx   = 1'b1;
            w_state_nx = BREAK;
          end
        end else begin
          w_clk_cnt_nx = r_clk_cnt + 1'b1;
        end
      end

      // A line stuck low must return high before a new start is armed.
      BREAK: begin
        if (w_rx_s) begin
          w_state_nx = IDLE;
        end
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_err;
  assign rx_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed bench for uart_rx against a sample-index frame model
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = UART_CLKS_PER_BIT;
  localparam int H = C / 2;

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 r_clk = ~r_clk;

  int checks = 0;
  int errors = 0;

  bit         wq[$];
  bit         wv[];
  bit         exp_v[];
  bit         exp_e[];
  bit         exp_b[];
  logic [7:0] exp_d[];

  int         obs_vcyc[$];
  logic [7:0] obs_vdat[$];
  int         obs_ecyc[$];
  logic [7:0] obs_edat[$];
  int         busy_run;
  int         busy_max;
  int         model_first_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic void add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) wq.push_back(v);
  endfunction

  function automatic void add_frame(input logic [7:0] b, input bit stop);
    add_level(1'b0, C);
    for (int i = 0; i < 8; i++) add_level(b[i], C);
    add_level(stop, C);
  endfunction

  function automatic bit w_at(input int k);
    if (k < 0 || k >= wv.size()) return 1'b1;
    return wv[k];
  endfunction

  // Line value the receiver acts on, indexed by rx_in sample number.
  function automatic bit ln(input int k);
`ifdef UART_RX_MAJORITY_EN
    bit a, b, c;
    a = w_at(k);
    b = w_at(k - 1);
    c = w_at(k - 2);
    return (a & b) | (a & c) | (b & c);
`else
    return w_at(k);
`endif
  endfunction

  function automatic void mark_busy(input int a, input int z);
    for (int k = a; k <= z; k++)
      if (k >= 0 && k < exp_b.size()) exp_b[k] = 1'b1;
  endfunction

  // A decision made with sample k becomes visible on the output after edge k+2.
  function automatic void build_model();
    int n_len, s, t, d, h;
    logic [7:0] b;
    n_len = wv.size();
    exp_v = new[n_len];
    exp_e = new[n_len];
    exp_b = new[n_len];
    exp_d = new[n_len];
    foreach (exp_v[i]) begin
      exp_v[i] = 1'b0;
      exp_e[i] = 1'b0;
      exp_b[i] = 1'b0;
      exp_d[i] = 8'h00;
    end
    model_first_v = -1;
    s = -2;
    while (s < n_len) begin
      t = s;
      while (t < n_len && ln(t)) t++;
      if (t + 2 >= n_len) break;
      if (ln(t + H)) begin
        mark_busy(t + 2, t + H + 1);
        s = t + H + 1;
        continue;
      end
      for (int i = 0; i < 8; i++) b[i] = ln(t + C * (i + 1) + H);
      d = t + 9 * C + H + 2;
      if (ln(d - 2)) begin
        mark_busy(t + 2, d - 1);
        if (d < n_len) begin
          exp_v[d] = 1'b1;
          if (model_first_v < 0) model_first_v = d;
          for (int k = d; k < n_len; k++) exp_d[k] = b;
        end
        s = d - 1;
      end else begin
        h = d - 1;
        while (h < n_len && !ln(h)) h++;
        mark_busy(t + 2, h + 1);
        if (d < n_len) exp_e[d] = 1'b1;
        s = h + 1;
      end
    end
  endfunction

  task automatic compare_cycle(input int n);
    check($sformatf("rx_valid@%0d", n), rx_valid, exp_v[n]);
    check($sformatf("frame_err@%0d", n), frame_err, exp_e[n]);
    check($sformatf("rx_busy@%0d", n), rx_busy, exp_b[n]);
    check($sformatf("rx_data@%0d", n), rx_data, exp_d[n]);
    if (rx_valid) begin
      obs_vcyc.push_back(n);
      obs_vdat.push_back(rx_data);
    end
    if (frame_err) begin
      obs_ecyc.push_back(n);
      obs_edat.push_back(rx_data);
    end
    busy_run = rx_busy ? busy_run + 1 : 0;
    if (busy_run > busy_max) busy_max = busy_run;
  endtask

  // Reset, then play the built waveform one sample per clock while comparing.
  task automatic run_segment();
    int n_len;
    n_len = wq.size();
    wv = new[n_len];
    foreach (wq[i]) wv[i] = wq[i];
    wq.delete();
    build_model();
    obs_vcyc.delete();
    obs_vdat.delete();
    obs_ecyc.delete();
    obs_edat.delete();
    busy_run = 0;
    busy_max = 0;
    @(negedge r_clk);
    r_rst = 1'b0;
    rx_in = 1'b1;
    repeat (3) begin
      @(negedge r_clk);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_rx_busy", rx_busy, 0);
      check("reset_rx_data", rx_data, 0);
    end
    r_rst = 1'b1;
    rx_in = wv[0];
    for (int n = 0; n < n_len; n++) begin
      @(negedge r_clk);
      compare_cycle(n);
      if (n + 1 < n_len) rx_in = wv[n + 1];
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         kind;
    logic [7:0] b;
    logic [7:0] dir_vals [3];
    dir_vals[0] = 8'h00;
    dir_vals[1] = 8'hFF;
    dir_vals[2] = 8'hA5;

    // Directed back-to-back frames; start edge at sample 4.
    add_level(1'b1, 4);
    for (int i = 0; i < 3; i++) add_frame(dir_vals[i], 1'b1);
    add_level(1'b1, 20);
    run_segment();
`ifdef UART_RX_MAJORITY_EN
    check("model_first_valid", model_first_v, 159);
`else
    check("model_first_valid", model_first_v, 158);
`endif
    check("dir_count", obs_vcyc.size(), 3);
    for (int i = 0; i < obs_vdat.size() && i < 3; i++)
      check($sformatf("dir_data%0d", i), obs_vdat[i], dir_vals[i]);
    if (obs_vcyc.size() > 0)
`ifdef UART_RX_MAJORITY_EN
      check("dir_latency", obs_vcyc[0] - 4, 155);
`else
      check("dir_latency", obs_vcyc[0] - 4, 154);
`endif

    // Loopback-style stream of 8'hDD with no gaps.
    add_level(1'b1, 2);
    for (int i = 0; i < 6; i++) add_frame(8'hDD, 1'b1);
    add_level(1'b1, 20);
    run_segment();
    check("loop_count", obs_vcyc.size(), 6);
    check("loop_errs", obs_ecyc.size(), 0);
    for (int i = 0; i < obs_vdat.size(); i++)
      check($sformatf("loop_data%0d", i), obs_vdat[i], 8'hDD);
    for (int i = 1; i < obs_vcyc.size(); i++)
      check($sformatf("loop_spacing%0d", i), obs_vcyc[i] - obs_vcyc[i - 1], 160);

    // Short low glitch.
    add_level(1'b1, 6);
    add_level(1'b0, 4);
    add_level(1'b1, 40);
    run_segment();
    check("glitch_valid", obs_vcyc.size(), 0);
    check("glitch_err", obs_ecyc.size(), 0);
    check("glitch_busy_bounded", busy_max <= H + 2, 1);
    check("glitch_busy_seen", busy_max > 0, 1);

    // Framing error held low, then recovery.
    add_level(1'b1, 5);
    add_frame(8'h96, 1'b1);
    add_level(1'b1, 3);
    add_frame(8'h3C, 1'b0);
    add_level(1'b0, 40);
    add_level(1'b1, 10);
    add_frame(8'h5A, 1'b1);
    add_level(1'b1, 20);
    run_segment();
    check("ferr_count", obs_ecyc.size(), 1);
    if (obs_edat.size() > 0) check("ferr_data_held", obs_edat[0], 8'h96);
    check("ferr_valid_count", obs_vcyc.size(), 2);
    if (obs_vdat.size() == 2) check("ferr_next_data", obs_vdat[1], 8'h5A);

    // Reset during data bit 4 of 8'hC3, then 8'h81.
    add_level(1'b1, 5);
    add_frame(8'hC3, 1'b1);
    wq = wq[0:5 + 5 * C + H - 1];
    run_segment();
    check("rst_partial_valid", obs_vcyc.size(), 0);
    add_level(1'b1, 3);
    add_frame(8'h81, 1'b1);
    add_level(1'b1, 20);
    run_segment();
    check("rst_after_count", obs_vcyc.size(), 1);
    if (obs_vdat.size() > 0) check("rst_after_data", obs_vdat[0], 8'h81);

`ifdef UART_RX_MAJORITY_EN
    // One-clock high spikes at every data-bit midpoint of 8'h00.
    add_level(1'b1, 4);
    add_frame(8'h00, 1'b1);
    add_level(1'b1, 20);
    for (int i = 0; i < 8; i++) wq[4 + C * (i + 1) + H] = 1'b1;
    run_segment();
    check("maj_count", obs_vcyc.size(), 1);
    if (obs_vdat.size() > 0) check("maj_data", obs_vdat[0], 8'h00);
    if (obs_vcyc.size() > 0) check("maj_latency", obs_vcyc[0] - 4, 155);
`endif

    // Randomized traffic: good frames, bad stops, short pulses and stray spikes.
    repeat (6) begin
      add_level(1'b1, 5);
      for (int f = 0; f < 8; f++) begin
        kind = $urandom_range(0, 9);
        b    = 8'($urandom_range(0, 255));
        if (kind == 0) begin
          add_level(1'b0, $urandom_range(1, C));
          add_level(1'b1, $urandom_range(1, 10));
        end else if (kind == 1) begin
          add_frame(b, 1'b0);
          add_level(1'b0, $urandom_range(0, 30));
          add_level(1'b1, $urandom_range(1, 10));
        end else begin
          add_frame(b, 1'b1);
          if ($urandom_range(0, 3) == 0)
            wq[wq.size() - 1 - $urandom_range(0, 10 * C - 1)] ^= 1'b1;
          add_level(1'b1, $urandom_range(0, 12));
        end
      end
      add_level(1'b1, 20);
      run_segment();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
